dcf77_generator: RTL

//  Generates a DCF77-format time-code pulse train from 59-bit minute frames supplied by software.

---
 rtl/dcf77_pkg.sv | 16 +
 rtl/dcf77_frame_buffer.sv | 40 ++++
 rtl/dcf77_generator.sv | 110 +++++++++++
 3 files changed

// File: rtl/dcf77_pkg.sv
// rtl/dcf77_pkg.sv - shared DCF77 constants, state encoding and default cycle counts
package dcf77_pkg;
  localparam int FRAME_BITS              = 59;
  localparam int MINUTE_MARK_IDX         = 59;
  localparam int TICK_BITS               = 31;
  localparam int DEFAULT_CLOCK_FREQUENCY = 16_000_000;
  localparam int DEFAULT_PULSE0_CYCLES   = DEFAULT_CLOCK_FREQUENCY / 10;
  localparam int DEFAULT_PULSE1_CYCLES   = DEFAULT_CLOCK_FREQUENCY / 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_MARK  = 2'd3
  } dcf77_state_e;
endpackage

// File: rtl/dcf77_frame_buffer.sv
// rtl/dcf77_frame_buffer.sv - one-deep minute frame holding register with bypass and underrun
module dcf77_frame_buffer
  import dcf77_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic                  load,
  output logic [FRAME_BITS-1:0] active_frame,
  output logic                  underrun
);
  logic [FRAME_BITS-1:0] hold_data;

  // frame_ready doubles as the "buffer empty" flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_ready  <= 1'b1;
      hold_data    <= '0;
      active_frame <= '0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (load) begin
        if (!frame_ready) begin
          active_frame <= hold_data;
          frame_ready  <= 1'b1;
        end else if (frame_valid) begin
          active_frame <= frame_data;
        end else begin
          underrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        hold_data   <= frame_data;
        frame_ready <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dcf77_generator.sv
// rtl/dcf77_generator.sv - DCF77 pulse train generator: second timer, FSM and pulse-width compare
module dcf77_generator
  import dcf77_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int PULSE0_CYCLES   = CLOCK_FREQUENCY / 10,
  parameter int PULSE1_CYCLES   = CLOCK_FREQUENCY / 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  dcf77_out,
  output logic                  sec_tick,
  output logic                  minute_start,
  output logic [5:0]            sec_index,
  output logic                  underrun
);
  localparam logic [TICK_BITS-1:0] SEC_LAST = TICK_BITS'(CLOCK_FREQUENCY - 1);
  localparam logic [TICK_BITS-1:0] P0_LAST  = TICK_BITS'(PULSE0_CYCLES - 1);
  localparam logic [TICK_BITS-1:0] P1_LAST  = TICK_BITS'(PULSE1_CYCLES - 1);
  localparam logic [5:0]           MARK_IDX = 6'(MINUTE_MARK_IDX);

  dcf77_state_e          state, state_nxt;
  logic [TICK_BITS-1:0]  tick, tick_nxt, pulse_last;
  logic [5:0]            sec_nxt;
  logic                  out_nxt, sec_tick_nxt, minute_nxt, load, active_bit;
  logic [FRAME_BITS-1:0] active_frame;

  dcf77_frame_buffer u_buffer (
    .clk          (clk),
    .reset        (reset),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .load         (load),
    .active_frame (active_frame),
    .underrun     (underrun)
  );

  always_comb begin
    active_bit = 1'b0;
    if (sec_index < 6'(FRAME_BITS)) active_bit = active_frame[sec_index];
    pulse_last = active_bit ? P1_LAST : P0_LAST;
  end

  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick + 31'd1;
    sec_nxt      = sec_index;
    out_nxt      = dcf77_out;
    sec_tick_nxt = 1'b0;
    minute_nxt   = 1'b0;
    load         = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      tick_nxt  = '0;
      sec_nxt   = '0;
      out_nxt   = 1'b0;
    end else if (state == ST_IDLE) begin
      // start-up always begins with a silent mark second so the first frame is aligned
      state_nxt    = ST_MARK;
      tick_nxt     = '0;
      sec_nxt      = MARK_IDX;
      sec_tick_nxt = 1'b1;
      out_nxt      = 1'b0;
    end else if (tick == SEC_LAST) begin
      tick_nxt     = '0;
      sec_tick_nxt = 1'b1;
      if (sec_index == MARK_IDX) begin
        sec_nxt    = '0;
        load       = 1'b1;
        minute_nxt = 1'b1;
        state_nxt  = ST_PULSE;
        out_nxt    = 1'b1;
      end else if (sec_index == MARK_IDX - 6'd1) begin
        sec_nxt   = MARK_IDX;
        state_nxt = ST_MARK;
        out_nxt   = 1'b0;
      end else begin
        sec_nxt   = sec_index + 6'd1;
        state_nxt = ST_PULSE;
        out_nxt   = 1'b1;
      end
    end else if (state == ST_PULSE && tick == pulse_last) begin
      state_nxt = ST_GAP;
      out_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick         <= '0;
      sec_index    <= '0;
      dcf77_out    <= 1'b0;
      sec_tick     <= 1'b0;
      minute_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick         <= tick_nxt;
      sec_index    <= sec_nxt;
      dcf77_out    <= out_nxt;
      sec_tick     <= sec_tick_nxt;
      minute_start <= minute_nxt;
    end
  end
endmodule
